// File: rtl/fetch_decode_reg.sv
// rtl/fetch_decode_reg.sv - IF/ID pipeline register with stall, flush and event counters
// Priority per edge: rst > flush_d > stall_d > capture.
module fetch_decode_reg #(
   parameter int                  D_WIDTH = 32,
   parameter int                  P_WIDTH = 32,
   parameter logic [D_WIDTH-1:0]  NOP     = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] instr_f,
   input  logic [P_WIDTH-1:0] pc_f,
   input  logic [P_WIDTH-1:0] pc_4f,
   input  logic               valid_f,
   input  logic               stall_d,
   input  logic               flush_d,
   output logic [D_WIDTH-1:0] instr_d,
   output logic [P_WIDTH-1:0] pc_d,
   output logic [P_WIDTH-1:0] pc_4d,
   output logic               valid_d,
   output logic [15:0]        stall_cnt,
   output logic [15:0]        flush_cnt,
   output logic [31:0]        instr_cnt
);

   logic [D_WIDTH-1:0] instr_q, instr_d_nxt;
   logic [P_WIDTH-1:0] pc_q, pc_d_nxt;
   logic [P_WIDTH-1:0] pc_4_q, pc_4_d;
   logic               valid_q, valid_d_nxt;
   logic [15:0]        stall_cnt_q, stall_cnt_d;
   logic [15:0]        flush_cnt_q, flush_cnt_d;
   logic [31:0]        instr_cnt_q, instr_cnt_d;

   always_comb begin
      instr_d_nxt = instr_q;
      pc_d_nxt    = pc_q;
      pc_4_d      = pc_4_q;
      valid_d_nxt = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (flush_d) begin
         instr_d_nxt = NOP;
         pc_d_nxt    = '0;
         pc_4_d      = '0;
         valid_d_nxt = 1'b0;
         if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
      end else if (stall_d) begin
         if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         // Invalid fetch slots enter decode as a bubble, never as garbage
         instr_d_nxt = valid_f ? instr_f : NOP;
         pc_d_nxt    = pc_f;
         pc_4_d      = pc_4f;
         valid_d_nxt = valid_f;
         if (valid_f) instr_cnt_d = instr_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q     <= NOP;
         pc_q        <= '0;
         pc_4_q      <= '0;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         instr_q     <= instr_d_nxt;
         pc_q        <= pc_d_nxt;
         pc_4_q      <= pc_4_d;
         valid_q     <= valid_d_nxt;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign instr_d   = instr_q;
   assign pc_d      = pc_q;
   assign pc_4d     = pc_4_q;
   assign valid_d   = valid_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb/tb_fetch_decode_reg.sv - scoreboard bench for fetch_decode_reg
// Driver pushes reference-model predictions; monitor pops and compares each cycle.
module tb_fetch_decode_reg;

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
      int          scnt;
      int          fcnt;
      longint      icnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr_f = '0, pc_f = '0, pc_4f = '0;
   logic        valid_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0;
   logic [31:0] instr_d, pc_d, pc_4d;
   logic        valid_d;
   logic [15:0] stall_cnt, flush_cnt;
   logic [31:0] instr_cnt;

   int checks = 0;
   int failures = 0;
   exp_t sb_q[$];
   exp_t m;

   always #5 clk = ~clk;

   fetch_decode_reg dut (
      .clk(clk), .rst(rst), .instr_f(instr_f), .pc_f(pc_f), .pc_4f(pc_4f),
      .valid_f(valid_f), .stall_d(stall_d), .flush_d(flush_d),
      .instr_d(instr_d), .pc_d(pc_d), .pc_4d(pc_4d), .valid_d(valid_d),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .instr_cnt(instr_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: pipeline slot contents plus event tallies in plain integers
   task automatic model_step();
      if (rst) begin
         m.instr = NOP_W; m.pc = 0; m.pc4 = 0; m.valid = 0;
         m.scnt = 0; m.fcnt = 0; m.icnt = 0;
      end else if (flush_d) begin
         m.instr = NOP_W; m.pc = 0; m.pc4 = 0; m.valid = 0;
         m.fcnt = (m.fcnt + 1 > 65535) ? 65535 : m.fcnt + 1;
      end else if (stall_d) begin
         m.scnt = (m.scnt + 1 > 65535) ? 65535 : m.scnt + 1;
      end else begin
         m.pc = pc_f; m.pc4 = pc_4f; m.valid = valid_f;
         m.instr = valid_f ? instr_f : NOP_W;
         if (valid_f) m.icnt = (m.icnt + 1) % 64'h1_0000_0000;
      end
   endtask

   task automatic cycle(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic v, input logic s, input logic f);
      @(negedge clk);
      rst = r; instr_f = ins; pc_f = pc; pc_4f = pc4; valid_f = v; stall_d = s; flush_d = f;
      @(posedge clk);
      model_step();
      sb_q.push_back(m);
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("instr_d", 64'(instr_d), 64'(e.instr));
         chk("pc_d", 64'(pc_d), 64'(e.pc));
         chk("pc_4d", 64'(pc_4d), 64'(e.pc4));
         chk("valid_d", 64'(valid_d), 64'(e.valid));
         chk("stall_cnt", 64'(stall_cnt), 64'(e.scnt));
         chk("flush_cnt", 64'(flush_cnt), 64'(e.fcnt));
         chk("instr_cnt", 64'(instr_cnt), 64'(e.icnt));
      end
   end

   initial begin
      int wait_cycles;
      logic [31:0] pc;
      // Reset with all competing requests asserted
      cycle(1, 32'hDEADBEEF, 32'h40, 32'h44, 1, 1, 1);
      cycle(1, 32'hDEADBEEF, 32'h40, 32'h44, 1, 1, 1);
      #2;
      chk("rst_instr", 64'(instr_d), 64'h13);
      chk("rst_valid", 64'(valid_d), 64'h0);
      chk("rst_cnts", {16'(0), stall_cnt, flush_cnt, instr_cnt[15:0]}, 64'h0);

      cycle(0, 32'h00500093, 32'h10, 32'h14, 1, 0, 0);
      #2;
      chk("cap_instr", 64'(instr_d), 64'h00500093);
      chk("cap_pc", {pc_d, pc_4d}, {32'h10, 32'h14});
      chk("cap_icnt", 64'(instr_cnt), 64'd1);

      for (int i = 0; i < 3; i++) cycle(0, 32'hA000_0000 + i, 32'h100 + i, 32'h104 + i, 1, 1, 0);
      #2;
      chk("stall_instr", 64'(instr_d), 64'h00500093);
      chk("stall_cnt3", 64'(stall_cnt), 64'd3);
      chk("stall_icnt", 64'(instr_cnt), 64'd1);
      cycle(0, 32'h00A00113, 32'h14, 32'h18, 1, 0, 0);
      #2;
      chk("post_stall_cap", 64'(instr_d), 64'h00A00113);

      cycle(0, 32'hFFFF_FFFF, 32'h200, 32'h204, 1, 1, 1);
      #2;
      chk("flush_pri", {instr_d, pc_d}, {32'h13, 32'h0});
      chk("flush_cnts", {stall_cnt, flush_cnt}, {16'd3, 16'd1});

      cycle(0, 32'h12345678, 32'h20, 32'h24, 0, 0, 0);
      #2;
      chk("inval_fetch", {instr_d, pc_d}, {32'h13, 32'h20});
      chk("inval_icnt", 64'(instr_cnt), 64'd2);

      // Flush then stall keeps the bubble; reset mid-stall discards the held word
      cycle(0, 32'h1111_1111, 32'h30, 32'h34, 1, 0, 1);
      cycle(0, 32'h2222_2222, 32'h34, 32'h38, 1, 1, 0);
      cycle(0, 32'h3333_3333, 32'h38, 32'h3C, 1, 0, 0);
      cycle(0, 32'h4444_4444, 32'h3C, 32'h40, 1, 1, 0);
      cycle(1, 32'h5555_5555, 32'h40, 32'h44, 1, 1, 0);
      cycle(0, 32'h6666_6666, 32'h44, 32'h48, 1, 0, 0);

      for (int i = 0; i < 600; i++) begin
         pc = $urandom & 32'hFFFF_FFFC;
         cycle(($urandom_range(0, 39) == 0), $urandom, pc, pc + 4,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0);
      end

      cycle(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 65540; i++) cycle(0, $urandom, $urandom, $urandom, 1, 1, 0);
      #2;
      chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
      cycle(0, $urandom, $urandom, $urandom, 1, 0, 1);
      #2;
      chk("sat_flush", {stall_cnt, flush_cnt}, {16'hFFFF, 16'd1});

      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
